// File: rtl/td4_pkg.sv
// Shared TD4 definitions: widths, opcodes, sequencer FSM states.
// Used by the sequencer, its PC register and the decode stage.
package td4_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int INST_W = 8;

  localparam logic [3:0] OP_JNC = 4'b1110;
  localparam logic [3:0] OP_JMP = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  function automatic logic is_jump(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JNC);
  endfunction

endpackage

// File: rtl/td4_pc.sv
// TD4 program counter: 4-bit register, load or mod-16 increment.
// Load takes priority over increment.
module td4_pc
  import td4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load)
      pc_d = load_val;
    else if (inc)
      pc_d = pc_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pc_q <= '0;
    else
      pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/td4_sequencer.sv
// TD4 control sequencer: fetch/decode/execute/writeback, carry, branches.
// Optional jump-to-self halt detection: define TD4_HALT_DETECT_EN.
module td4_sequencer
  import td4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [INST_W-1:0] rom_data,
  input  logic              carry_in,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [INST_W-1:0] inst,
  output logic              dec_valid,
  output logic              wb_en,
  output logic [ADDR_W-1:0] pc,
  output logic              carry,
  output logic              halted,
  output logic [2:0]        state
);

  state_e            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              dv_q, dv_d;
  logic              wb_q, wb_d;
  logic              carry_q, carry_d;
  logic              csamp_q, csamp_d;
  logic              taken_q, taken_d;
  logic              halted_q, halted_d;

  logic [3:0]        op;
  logic [3:0]        imm;
  logic              is_jmp;
  logic              is_jnc;
  logic              pc_load;
  logic              pc_inc;
  logic [ADDR_W-1:0] pc_w;

  assign op     = inst_q[7:4];
  assign imm    = inst_q[3:0];
  assign is_jmp = (op == OP_JMP);
  assign is_jnc = (op == OP_JNC);

`ifdef TD4_HALT_DETECT_EN
  logic self_jmp;
  assign self_jmp = is_jmp && (imm == pc_w);
`endif

  always_comb begin
    state_d  = state_q;
    inst_d   = inst_q;
    dv_d     = 1'b0;
    wb_d     = 1'b0;
    carry_d  = carry_q;
    csamp_d  = csamp_q;
    taken_d  = taken_q;
    halted_d = halted_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (run)
          state_d = ST_FETCH;
      end
      ST_FETCH: begin
        inst_d  = rom_data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        dv_d    = 1'b1;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        csamp_d = carry_in;
        // JNC looks at the flag left by the previous instruction
        taken_d = is_jmp | (is_jnc & ~carry_q);
        state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        wb_d    = ~is_jump(op);
        carry_d = is_jump(op) ? 1'b0 : csamp_q;
        pc_load = taken_q;
        pc_inc  = ~taken_q;
        state_d = run ? ST_FETCH : ST_IDLE;
`ifdef TD4_HALT_DETECT_EN
        if (self_jmp) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
`endif
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      inst_q   <= '0;
      dv_q     <= 1'b0;
      wb_q     <= 1'b0;
      carry_q  <= 1'b0;
      csamp_q  <= 1'b0;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      dv_q     <= dv_d;
      wb_q     <= wb_d;
      carry_q  <= carry_d;
      csamp_q  <= csamp_d;
      taken_q  <= taken_d;
      halted_q <= halted_d;
    end
  end

  td4_pc u_pc (
    .clk      (clk),
    .rst      (rst),
    .load     (pc_load),
    .load_val (imm),
    .inc      (pc_inc),
    .pc       (pc_w)
  );

  assign rom_addr  = pc_w;
  assign pc        = pc_w;
  assign inst      = inst_q;
  assign dec_valid = dv_q;
  assign wb_en     = wb_q;
  assign carry     = carry_q;
  assign halted    = halted_q;
  assign state     = state_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// Directed bench for td4_sequencer with ROM model and result scoreboard.
// Also builds with TD4_HALT_DETECT_EN to cover the halt path.
module tb_td4_sequencer;
  import td4_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] rom_data;
  logic       carry_in;
  logic [3:0] rom_addr;
  logic [7:0] inst;
  logic       dec_valid;
  logic       wb_en;
  logic [3:0] pc;
  logic       carry;
  logic       halted;
  logic [2:0] state;

  logic [7:0] rom [16];

  typedef struct packed {
    logic [3:0] pc;
    logic       c;
    logic       wb;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] m_pc;
  logic       m_c;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  td4_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .rom_data  (rom_data),
    .carry_in  (carry_in),
    .rom_addr  (rom_addr),
    .inst      (inst),
    .dec_valid (dec_valid),
    .wb_en     (wb_en),
    .pc        (pc),
    .carry     (carry),
    .halted    (halted),
    .state     (state)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},    8'(pc), 8'h0);
    chk({tag, "_addr"},  8'(rom_addr), 8'h0);
    chk({tag, "_carry"}, 8'(carry), 8'h0);
    chk({tag, "_inst"},  inst, 8'h00);
    chk({tag, "_dv"},    8'(dec_valid), 8'h0);
    chk({tag, "_wb"},    8'(wb_en), 8'h0);
    chk({tag, "_halt"},  8'(halted), 8'h0);
    chk({tag, "_state"}, 8'(state), 8'(ST_IDLE));
  endtask

  // Called #1 into a FETCH cycle; runs one instruction to the next cycle.
  task automatic exec(input logic ci, input logic drop);
    logic [7:0] ir;
    logic       jmp;
    logic       jnc;
    logic       tk;
    exp_t       e;
    ir   = rom[m_pc];
    jmp  = (ir[7:4] == 4'b1111);
    jnc  = (ir[7:4] == 4'b1110);
    tk   = jmp | (jnc & ~m_c);
    e.wb = ~(jmp | jnc);
    e.c  = (jmp | jnc) ? 1'b0 : ci;
    e.pc = tk ? ir[3:0] : m_pc + 4'd1;
    e.st = drop ? 3'd0 : 3'd1;
`ifdef TD4_HALT_DETECT_EN
    if (jmp && ir[3:0] == m_pc)
      e.st = 3'd5;
`endif
    sb.push_back(e);
    chk("fetch_state", 8'(state), 8'(ST_FETCH));
    chk("fetch_addr", 8'(rom_addr), 8'(m_pc));
    tick;
    if (drop)
      run = 1'b0;
    chk("dec_inst", inst, ir);
    chk("dec_dv", 8'(dec_valid), 8'h0);
    chk("dec_addr", 8'(rom_addr), 8'(m_pc));
    tick;
    carry_in = ci;
    chk("exe_dv", 8'(dec_valid), 8'h1);
    chk("exe_wb", 8'(wb_en), 8'h0);
    tick;
    carry_in = ~ci;
    chk("wb_dv", 8'(dec_valid), 8'h0);
    chk("wb_wb", 8'(wb_en), 8'h0);
    chk("wb_pc", 8'(pc), 8'(m_pc));
    tick;
    e = sb.pop_front();
    chk("post_wb", 8'(wb_en), 8'(e.wb));
    chk("post_dv", 8'(dec_valid), 8'h0);
    chk("post_pc", 8'(pc), 8'(e.pc));
    chk("post_carry", 8'(carry), 8'(e.c));
    chk("post_state", 8'(state), 8'(e.st));
    chk("post_halt", 8'(halted), 8'(e.st == 3'd5));
    m_pc = e.pc;
    m_c  = e.c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b0;
    run      = 1'b0;
    carry_in = 1'b0;
    for (int i = 0; i < 16; i++)
      rom[i] = 8'(i);
    rom[0] = 8'h0A;
    m_pc = 4'd0;
    m_c  = 1'b0;

    repeat (2) tick;
    chk_reset("rst");

    rst = 1'b1;
    run = 1'b1;
    chk("idle_state", 8'(state), 8'(ST_IDLE));
    tick;

    // Sixteen non-jumps: PC wraps 15 -> 0 with carry only from carry_in
    for (int i = 0; i < 16; i++)
      exec(i % 3 == 1, 1'b0);
    chk("wrap_pc", 8'(pc), 8'h0);

    rom[3] = 8'hE9;
    rom[4] = 8'hF0;
    rom[7] = 8'hF5;
    rom[9] = 8'hF6;

    exec(1'b0, 1'b0);
    exec(1'b0, 1'b0);
    exec(1'b1, 1'b0);
    exec(1'b1, 1'b0);
    chk("jnc_nt_pc", 8'(pc), 8'h4);
    exec(1'b1, 1'b0);
    exec(1'b0, 1'b0);
    exec(1'b0, 1'b0);
    exec(1'b0, 1'b0);
    exec(1'b0, 1'b0);
    chk("jnc_t_pc", 8'(pc), 8'h9);
    exec(1'b0, 1'b0);
    exec(1'b1, 1'b0);
    exec(1'b1, 1'b0);
    chk("jmp_pc", 8'(pc), 8'h5);

    exec(1'b1, 1'b1);
    tick;
    chk("drop_idle", 8'(state), 8'(ST_IDLE));
    chk("drop_pc", 8'(pc), 8'h6);
    chk("drop_carry", 8'(carry), 8'h1);
    run = 1'b1;
    tick;
    chk("resume_state", 8'(state), 8'(ST_FETCH));

    tick;
    tick;
    chk("rst_exe_dv", 8'(dec_valid), 8'h1);
    carry_in = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk_reset("rst_mid");
    tick;
    chk("rst_mid_nowb", 8'(wb_en), 8'h0);
    sb.delete();
    m_pc = 4'd0;
    m_c  = 1'b0;
    rst  = 1'b1;
    run  = 1'b1;
    tick;

    rom[3] = 8'hF3;
    exec(1'b0, 1'b0);
    exec(1'b0, 1'b0);
    exec(1'b0, 1'b0);
    exec(1'b0, 1'b0);
`ifdef TD4_HALT_DETECT_EN
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("halt_dv", 8'(dec_valid), 8'h0);
      chk("halt_addr", 8'(rom_addr), 8'h3);
      chk("halt_flag", 8'(halted), 8'h1);
      chk("halt_state", 8'(state), 8'(ST_HALT));
    end
`else
    exec(1'b0, 1'b0);
    exec(1'b0, 1'b0);
    chk("self_pc", 8'(pc), 8'h3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
